alu_mul_sequencer: RTL and testbench
====================================

Name: alu_mul_sequencer

Overview:
- Multi-cycle 16x16 multiplier that computes the low 16 bits of a product by repeatedly issuing add operations to the shared combinational Hack ALU.
- Owns the ALU control bits (zx, nx, zy, ny, f, no) and operand buses while busy, and drives a harmless zero code when idle.
- Sits beside the ALU; a later CPU extension uses it for a multiply instruction through a start/done handshake.

Parameters:
- WIDTH, 16, datapath width; fixed at the Hack word size, and no other value is supported.
- EARLY_EXIT, 1, when 1 the loop stops once remaining multiplier bits are all zero; when 0 it always runs 16 iterations.

Ports:
- clk  input  1  rising-edge clock
- reset  input  1  synchronous, active-high reset
- start  input  1  request; sampled only in IDLE
- a  input  16  multiplicand, two's complement
- b  input  16  multiplier, two's complement
- busy  output  1  high from the cycle after start is accepted through the DONE cycle
- done  output  1  single-cycle pulse; product is valid
- product  output  16  result register, held until the next accepted start
- alu_x  output  16  ALU x operand
- alu_y  output  16  ALU y operand
- alu_zx, alu_nx, alu_zy, alu_ny, alu_f, alu_no  output  1 each  ALU control bits
- alu_out  input  16  ALU result, same cycle (combinational ALU)

Behaviour:
- Clock and reset: one clock, clk. Reset is synchronous and active-high on reset.
- Internal registers: acc[15:0], mcand[15:0], mplier[15:0], cnt[4:0], state.
- States: IDLE, ADD, DBL, DONE.
- Reset: at the first clk edge with reset=1, state goes to IDLE and all registers (including product) clear to 0. busy=0, done=0.
- Reset mid-operation: same effect. The operation is abandoned and no done pulse is produced.
- Outputs in IDLE and DONE:
  - ALU code "constant 0" (zx=1, nx=0, zy=1, ny=0, f=1, no=0).
  - alu_x = alu_y = 0.
- All ALU drive outputs decode from registered state only; there is no combinational path from start, a or b.
- IDLE:
  - start=1 latches mcand<=a, mplier<=b, acc<=0, cnt<=0, and moves to ADD.
  - start=0 stays in IDLE.
- ADD (one cycle):
  - alu_x=acc, alu_y=mcand, ALU code "x+y" (0,0,0,0,1,0).
  - If mplier[0]=1, acc<=alu_out; otherwise acc is held. The ALU is still driven with x+y and its result is ignored.
  - Next state is DBL.
- DBL (one cycle):
  - alu_x=alu_y=mcand, ALU code "x+y".
  - mcand<=alu_out, mplier<=mplier>>1 (logical), cnt<=cnt+1.
  - Exit to DONE if cnt=15, or if EXIT_EARLY=1 and (mplier>>1)=0. Otherwise return to ADD.
- DONE (one cycle): product<=acc is captured on entry, so product is valid while done=1. done=1, busy=1, then IDLE.
- Latency:
  - Let k = max(1, bit length of b) when EARLY_EXIT=1, else k=16.
  - The state sequence after acceptance is (ADD, DBL) repeated k times, then DONE.
  - done is high in the (2k+1)th cycle after the accepting edge.
- Arithmetic: all sums are modulo 2^16 with ALU overflow discarded. This gives the correct low 16 bits for signed and unsigned operands.
  - Negative b has bit 15 set, so k=16.
- start while busy (ADD/DBL/DONE) is ignored and not queued. start in the cycle after DONE (IDLE) is accepted normally.
- a and b may change freely after the accepting edge.
- product and the ALU outputs never show X after reset.

Test Plan:
- Reset, then start with a=3, b=5: done pulses in cycle 7 after acceptance (k=3), product=15. During ADD cycles alu_zx..alu_no=0,0,0,0,1,0; in IDLE they are 1,0,1,0,1,0 with alu_x=alu_y=0.
- a=0xFFFD (-3), b=7: done in cycle 7, product=0xFFEB (-21). Then a=7, b=0xFFFD: done in cycle 33, product=0xFFEB.
- a=1234, b=0: done in cycle 3, product=0. a=0x7FFF, b=2: done in cycle 5, product=0xFFFE (wraps). With EARLY_EXIT=0, a=3, b=5: done in cycle 33, product=15.
- a=2, b=3 accepted; start pulsed with a=9, b=9 in cycles 2 and 4: ignored, done in cycle 5 with product=6. A start in the cycle after done is accepted and yields the new result.
- Start a=5, b=0x00FF, then assert reset in cycle 6: next cycle busy=0, done=0, product=0, IDLE ALU code. No done pulse appears for 40 cycles. A fresh start a=5, b=3 yields product=15.

Source files
------------

// File: rtl/alu_mul_sequencer.sv
// Shift-and-add 16x16 multiplier (low 16 bits) that borrows the shared Hack ALU
// for every addition, driving it with a constant-zero code whenever idle.
module alu_mul_sequencer #(
  parameter int WIDTH      = 16,
  parameter bit EARLY_EXIT = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] product,
  output logic [WIDTH-1:0] alu_x,
  output logic [WIDTH-1:0] alu_y,
  output logic             alu_zx,
  output logic             alu_nx,
  output logic             alu_zy,
  output logic             alu_ny,
  output logic             alu_f,
  output logic             alu_no,
  input  logic [WIDTH-1:0] alu_out
);

  typedef enum logic [1:0] {IDLE, ADD, DBL, DONE} state_t;

  state_t           state;
  logic [WIDTH-1:0] acc;
  logic [WIDTH-1:0] mcand;
  logic [WIDTH-1:0] mplier;
  logic [4:0]       cnt;

  logic [WIDTH-1:0] mplier_shr;
  logic             last_iter;

  assign mplier_shr = mplier >> 1;
  // Early exit only once no multiplier bits remain to be consumed.
  assign last_iter  = (cnt == 5'd15) || (EARLY_EXIT && (mplier_shr == '0));

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      cnt     <= '0;
      product <= '0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            mcand  <= a;
            mplier <= b;
            acc    <= '0;
            cnt    <= '0;
            busy   <= 1'b1;
            state  <= ADD;
          end
        end
        ADD: begin
          if (mplier[0]) begin
            acc <= alu_out;
          end
          state <= DBL;
        end
        DBL: begin
          mcand  <= alu_out;
          mplier <= mplier_shr;
          cnt    <= cnt + 5'd1;
          if (last_iter) begin
            product <= acc;
            done    <= 1'b1;
            state   <= DONE;
          end else begin
            state <= ADD;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // ALU drive depends on registered state only; idle code yields constant 0.
  always_comb begin
    alu_x  = '0;
    alu_y  = '0;
    alu_zx = 1'b1;
    alu_nx = 1'b0;
    alu_zy = 1'b1;
    alu_ny = 1'b0;
    alu_f  = 1'b1;
    alu_no = 1'b0;
    if (state == ADD) begin
      alu_x  = acc;
      alu_y  = mcand;
      alu_zx = 1'b0;
      alu_zy = 1'b0;
    end else if (state == DBL) begin
      alu_x  = mcand;
      alu_y  = mcand;
      alu_zx = 1'b0;
      alu_zy = 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_mul_sequencer.sv
// Bench for alu_mul_sequencer: two instances (early exit on/off) each attached
// to a behavioural Hack ALU; table vectors, corner sequences and random ops.
module tb_alu_mul_sequencer;

  logic        clk = 1'b0;
  logic        reset;
  logic        start_e, start_f;
  logic [15:0] a, b;

  logic        busy_e, done_e, busy_f, done_f;
  logic [15:0] product_e, product_f;
  logic [15:0] x_e, y_e, x_f, y_f, out_e, out_f;
  logic        zx_e, nx_e, zy_e, ny_e, f_e, no_e;
  logic        zx_f, nx_f, zy_f, ny_f, f_f, no_f;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [15:0] hack_alu(input logic [15:0] x, input logic [15:0] y,
                                           input logic [5:0] c);
    logic [15:0] xx, yy, o;
    xx = c[5] ? 16'h0 : x;
    xx = c[4] ? ~xx : xx;
    yy = c[3] ? 16'h0 : y;
    yy = c[2] ? ~yy : yy;
    o  = c[1] ? xx + yy : xx & yy;
    return c[0] ? ~o : o;
  endfunction

  assign out_e = hack_alu(x_e, y_e, {zx_e, nx_e, zy_e, ny_e, f_e, no_e});
  assign out_f = hack_alu(x_f, y_f, {zx_f, nx_f, zy_f, ny_f, f_f, no_f});

  alu_mul_sequencer #(.WIDTH(16), .EARLY_EXIT(1'b1)) dut (
    .clk(clk), .reset(reset), .start(start_e), .a(a), .b(b),
    .busy(busy_e), .done(done_e), .product(product_e),
    .alu_x(x_e), .alu_y(y_e),
    .alu_zx(zx_e), .alu_nx(nx_e), .alu_zy(zy_e), .alu_ny(ny_e), .alu_f(f_e), .alu_no(no_e),
    .alu_out(out_e)
  );

  alu_mul_sequencer #(.WIDTH(16), .EARLY_EXIT(1'b0)) dut_full (
    .clk(clk), .reset(reset), .start(start_f), .a(a), .b(b),
    .busy(busy_f), .done(done_f), .product(product_f),
    .alu_x(x_f), .alu_y(y_f),
    .alu_zx(zx_f), .alu_nx(nx_f), .alu_zy(zy_f), .alu_ny(ny_f), .alu_f(f_f), .alu_no(no_f),
    .alu_out(out_f)
  );

  // Reference: product is the true product modulo 2^16; latency from bit length of b.
  function automatic logic [15:0] ref_product(input logic [15:0] ra, input logic [15:0] rb);
    int unsigned p;
    p = int'(ra) * int'(rb);
    return p[15:0];
  endfunction

  function automatic int ref_latency(input logic [15:0] rb, input bit early);
    int bl;
    bl = 0;
    for (int i = 0; i < 16; i++) if (rb[i]) bl = i + 1;
    if (!early) return 33;
    return 2 * ((bl < 1) ? 1 : bl) + 1;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_idle_e(input string name);
    check({name, " ctrl"}, {26'd0, zx_e, nx_e, zy_e, ny_e, f_e, no_e}, 32'b101010);
    check({name, " xy"}, {x_e, y_e}, 32'd0);
  endtask

  // One full operation; checks first ADD/DBL drive, latency, product and return to idle.
  task automatic run_op(input logic [15:0] ta, input logic [15:0] tb_b, input bit early,
                        input int exp_lat, input logic [15:0] exp_p, input string name);
    int lat;
    logic d, bz;
    a = ta;
    b = tb_b;
    if (early) start_e = 1'b1; else start_f = 1'b1;
    tick();
    start_e = 1'b0;
    start_f = 1'b0;
    a = 16'($urandom);
    b = 16'($urandom);
    if (early) begin
      check({name, " add ctrl"}, {26'd0, zx_e, nx_e, zy_e, ny_e, f_e, no_e}, 32'b000010);
      check({name, " add xy"}, {x_e, y_e}, {16'd0, ta});
    end
    lat = 0;
    for (int n = 1; n <= 60; n++) begin
      d  = early ? done_e : done_f;
      bz = early ? busy_e : busy_f;
      if (d) begin
        lat = n;
        break;
      end
      if (n == 2 && early) check({name, " dbl xy"}, {x_e, y_e}, {ta, ta});
      if (!bz) check({name, " busy"}, 32'(bz), 32'd1);
      tick();
    end
    check({name, " latency"}, 32'(lat), 32'(exp_lat));
    check({name, " product"}, 32'(early ? product_e : product_f), 32'(exp_p));
    $display("op %s a=%h b=%h early=%0d latency=%0d product=%h", name, ta, tb_b, early, lat,
             early ? product_e : product_f);
    tick();
    check({name, " after"}, {30'd0, early ? busy_e : busy_f, early ? done_e : done_f}, 32'd0);
  endtask

  typedef struct {
    logic [15:0] va;
    logic [15:0] vb;
    bit          early;
    int          lat;
    logic [15:0] prod;
  } vec_t;

  initial begin
    vec_t vecs[6];
    int   dones;
    logic [15:0] ra, rb;
    bit   re;

    vecs[0] = '{16'd3,      16'd5,      1'b1, 7,  16'd15};
    vecs[1] = '{16'hFFFD,   16'd7,      1'b1, 7,  16'hFFEB};
    vecs[2] = '{16'd7,      16'hFFFD,   1'b1, 33, 16'hFFEB};
    vecs[3] = '{16'd1234,   16'd0,      1'b1, 3,  16'd0};
    vecs[4] = '{16'h7FFF,   16'd2,      1'b1, 5,  16'hFFFE};
    vecs[5] = '{16'd3,      16'd5,      1'b0, 33, 16'd15};

    reset = 1'b1;
    start_e = 1'b0;
    start_f = 1'b0;
    a = 16'h0;
    b = 16'h0;
    tick();
    tick();
    reset = 1'b0;
    check("reset status", {busy_e, done_e, busy_f, done_f}, 32'd0);
    check("reset product", {product_e, product_f}, 32'd0);
    check_idle_e("reset idle");

    foreach (vecs[i])
      run_op(vecs[i].va, vecs[i].vb, vecs[i].early, vecs[i].lat, vecs[i].prod,
             $sformatf("vec%0d", i));
    check_idle_e("idle after vecs");

    // Starts while busy must be ignored; a start right after done is accepted.
    a = 16'd2;
    b = 16'd3;
    start_e = 1'b1;
    tick();
    start_e = 1'b0;
    a = 16'd9;
    b = 16'd9;
    tick();
    start_e = 1'b1;
    tick();
    start_e = 1'b0;
    tick();
    start_e = 1'b1;
    tick();
    start_e = 1'b0;
    check("ignored start done", 32'(done_e), 32'd1);
    check("ignored start product", 32'(product_e), 32'd6);
    $display("op ignored-start a=0002 b=0003 product=%h", product_e);
    tick();
    run_op(16'd9, 16'd9, 1'b1, ref_latency(16'd9, 1'b1), ref_product(16'd9, 16'd9), "after done");

    // Reset in the middle of an operation abandons it without a done pulse.
    a = 16'd5;
    b = 16'h00FF;
    start_e = 1'b1;
    tick();
    start_e = 1'b0;
    for (int n = 1; n < 6; n++) tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("midreset status", {busy_e, done_e}, 32'd0);
    check("midreset product", 32'(product_e), 32'd0);
    check_idle_e("midreset idle");
    dones = 0;
    for (int n = 0; n < 40; n++) begin
      if (done_e || busy_e) dones++;
      tick();
    end
    check("midreset no done", 32'(dones), 32'd0);
    $display("op mid-reset abandoned, activity cycles=%0d", dones);
    run_op(16'd5, 16'd3, 1'b1, 5, 16'd15, "post reset");

    for (int i = 0; i < 24; i++) begin
      ra = 16'($urandom);
      rb = 16'($urandom) >> $urandom_range(0, 16);
      re = (i % 6) != 5;
      run_op(ra, rb, re, ref_latency(rb, re), ref_product(ra, rb), $sformatf("rand%0d", i));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
